rep_umul_array: RTL

//  LANES-wide rate-coded unary multiplier array: each lane multiplies an incoming

---
 rtl/rep_umul_array.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rep_umul_array.sv
// rep_umul_array
//   A set of LANES rate-coded unary multipliers. Each lane multiplies the
//   incoming unary bitstream A[i] by a stored binary operand B_i and emits a
//   product bitstream. Each lane also counts the ones in its product stream
//   over a shared window of 2^WIN_LOG enabled cycles.
//   - Unipolar mode (BIPOLAR=0) is AND-type.
//   - Bipolar mode (BIPOLAR=1) is XNOR-type.
//
// Ports
//   iClk       clock, rising edge
//   iRstN      asynchronous active-low reset
//   A          input bitstreams, lane i = A[i]
//   B          operands, lane i = B[i*BITWIDTH +: BITWIDTH]
//   loadB      load all operands and restart the index counters
//   iEn        global stream enable
//   iClr       synchronous clear of stream/accumulator state (operands kept)
//   mult       registered product bits
//   oAcc       per-lane ones count of the last complete window
//   oAccValid  one-cycle pulse when oAcc is updated

module rep_umul_array #(
    parameter int BITWIDTH = 8,
    parameter int LANES    = 4,
    parameter int WIN_LOG  = 9,
    parameter int BIPOLAR  = 0
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic [LANES-1:0]             A,
    input  logic [LANES*BITWIDTH-1:0]    B,
    input  logic                         loadB,
    input  logic                         iEn,
    input  logic                         iClr,
    output logic [LANES-1:0]             mult,
    output logic [LANES*(WIN_LOG+1)-1:0] oAcc,
    output logic                         oAccValid
);

    localparam int AW = WIN_LOG + 1;

    logic [BITWIDTH-1:0] breg_q [LANES];
    logic [BITWIDTH-1:0] breg_d [LANES];
    logic [BITWIDTH-1:0] c1_q   [LANES];
    logic [BITWIDTH-1:0] c1_d   [LANES];
    logic [BITWIDTH-1:0] c0_q   [LANES];
    logic [BITWIDTH-1:0] c0_d   [LANES];
    logic [AW-1:0]       acc_q  [LANES];
    logic [AW-1:0]       acc_d  [LANES];
    logic [AW-1:0]       oacc_q [LANES];
    logic [AW-1:0]       oacc_d [LANES];
    logic [WIN_LOG-1:0]  wcnt_q;
    logic [WIN_LOG-1:0]  wcnt_d;
    logic [LANES-1:0]    mult_q;
    logic [LANES-1:0]    mult_d;
    logic                valid_q;
    logic                valid_d;

    logic [LANES-1:0]    prod;
    logic                win_end;

    // Each index counter walks 0..2^BITWIDTH-1. Comparing it against the
    // operand regenerates the B stream deterministically, so exactly Breg
    // ones come out per 2^BITWIDTH input ones. In bipolar mode, A=1 and
    // A=0 cycles each have their own counter, which gives the XNOR product.
    always_comb begin
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            if (BIPOLAR != 0) begin
                prod[i] = A[i] ? (c1_q[i] < breg_q[i]) : (c0_q[i] >= breg_q[i]);
            end else begin
                prod[i] = A[i] & (c1_q[i] < breg_q[i]);
            end
        end
    end

    assign win_end = iEn && (wcnt_q == '1);

    always_comb begin
        wcnt_d  = wcnt_q;
        mult_d  = mult_q;
        valid_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            breg_d[i] = breg_q[i];
            c1_d[i]   = c1_q[i];
            c0_d[i]   = c0_q[i];
            acc_d[i]  = acc_q[i];
            oacc_d[i] = oacc_q[i];
        end

        if (iClr) begin
            wcnt_d = '0;
            mult_d = '0;
            for (int i = 0; i < LANES; i++) begin
                if (loadB) begin
                    breg_d[i] = B[i*BITWIDTH +: BITWIDTH];
                end
                c1_d[i]   = '0;
                c0_d[i]   = '0;
                acc_d[i]  = '0;
                oacc_d[i] = '0;
            end
        end else begin
            if (iEn) begin
                mult_d = prod;
                wcnt_d = win_end ? '0 : wcnt_q + WIN_LOG'(1);
                valid_d = win_end;
                for (int i = 0; i < LANES; i++) begin
                    if (A[i]) begin
                        c1_d[i] = c1_q[i] + BITWIDTH'(1);
                    end else if (BIPOLAR != 0) begin
                        c0_d[i] = c0_q[i] + BITWIDTH'(1);
                    end
                    if (win_end) begin
                        oacc_d[i] = acc_q[i] + AW'(prod[i]);
                        acc_d[i]  = '0;
                    end else begin
                        acc_d[i]  = acc_q[i] + AW'(prod[i]);
                    end
                end
            end else begin
                mult_d = '0;
            end

            // An operand load restarts the streams and overrides any
            // counter increment from this same cycle.
            if (loadB) begin
                for (int i = 0; i < LANES; i++) begin
                    breg_d[i] = B[i*BITWIDTH +: BITWIDTH];
                    c1_d[i]   = '0;
                    c0_d[i]   = '0;
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wcnt_q  <= '0;
            mult_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                breg_q[i] <= '0;
                c1_q[i]   <= '0;
                c0_q[i]   <= '0;
                acc_q[i]  <= '0;
                oacc_q[i] <= '0;
            end
        end else begin
            wcnt_q  <= wcnt_d;
            mult_q  <= mult_d;
            valid_q <= valid_d;
            for (int i = 0; i < LANES; i++) begin
                breg_q[i] <= breg_d[i];
                c1_q[i]   <= c1_d[i];
                c0_q[i]   <= c0_d[i];
                acc_q[i]  <= acc_d[i];
                oacc_q[i] <= oacc_d[i];
            end
        end
    end

    always_comb begin
        oAcc = '0;
        for (int i = 0; i < LANES; i++) begin
            oAcc[i*AW +: AW] = oacc_q[i];
        end
    end

    assign mult      = mult_q;
    assign oAccValid = valid_q;

endmodule
